// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    // Identifies a requester. It is used for the last grant, the issued command
    // and the read-return tags.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_W    = 2'd1,
        GNT_A    = 2'd2,
        GNT_B    = 2'd3
    } gnt_t;

    // Map a one-hot grant vector {B, A, W} to the requester identity.
    function automatic gnt_t onehot_to_gnt(input logic [2:0] oh);
        gnt_t g;
        case (oh)
            3'b001:  g = GNT_W;
            3'b010:  g = GNT_A;
            3'b100:  g = GNT_B;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb3.sv
// Combinational 3-way round-robin selector. The caller holds the last-grant register.
module rr_arb3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,        // {B, A, W}
    input  gnt_t       last,
    output logic [2:0] gnt,        // one-hot {B, A, W}
    output gnt_t       next_last
);

    gnt_t sel_s;

    // Search starts at the requester after the last winner. GNT_NONE is treated like B, so W wins first.
    always_comb begin
        gnt = 3'b000;
        case (last)
            GNT_W: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else             gnt = 3'b000;
            end
            GNT_A: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else             gnt = 3'b000;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else             gnt = 3'b000;
            end
        endcase
    end

    // The last-grant pointer advances only when somebody actually wins.
    always_comb begin
        sel_s     = onehot_to_gnt(gnt);
        next_last = last;
        if (sel_s != GNT_NONE) begin
            next_last = sel_s;
        end else begin
            next_last = last;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between one writer and two readers.
// It issues one registered memory command per cycle and routes the tagged read data back to the reader that asked for it.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rda_req,
    input  logic [ADDR_W-1:0] rda_addr,
    output logic              rda_ack,
    output logic              rda_valid,
    output logic [DATA_W-1:0] rda_data,
    input  logic              rdb_req,
    input  logic [ADDR_W-1:0] rdb_addr,
    output logic              rdb_ack,
    output logic              rdb_valid,
    output logic [DATA_W-1:0] rdb_data,
    output logic              iWriteEnable,
    output logic [ADDR_W-1:0] iAddress,
    output logic [ADDR_W-1:0] iReadAddress,
    output logic [DATA_W-1:0] validdata,
    output logic              Readtoa,
    output logic              Readtob,
    input  logic [DATA_W-1:0] mem_data
);

    logic [2:0] req_s;
    logic [2:0] gnt_s;
    gnt_t       next_last_s;
    gnt_t       cmd_s;
    gnt_t       last_r;
    gnt_t       tag_r [RD_LAT+1];

    assign req_s = {rdb_req, rda_req, wr_req};

    rr_arb3 u_rr_arb3 (
        .req       (req_s),
        .last      (last_r),
        .gnt       (gnt_s),
        .next_last (next_last_s)
    );

    // Acks and the command to issue. Nothing is granted while reset is held.
    always_comb begin
        wr_ack  = 1'b0;
        rda_ack = 1'b0;
        rdb_ack = 1'b0;
        cmd_s   = GNT_NONE;
        if (reset_n) begin
            wr_ack  = gnt_s[0];
            rda_ack = gnt_s[1];
            rdb_ack = gnt_s[2];
            cmd_s   = onehot_to_gnt(gnt_s);
        end else begin
            cmd_s   = GNT_NONE;
        end
    end

    // Register the granted command toward the memory. Addresses and write data keep their last values when idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_r       <= GNT_B;
            iWriteEnable <= 1'b0;
            Readtoa      <= 1'b0;
            Readtob      <= 1'b0;
            iAddress     <= {ADDR_W{1'b0}};
            iReadAddress <= {ADDR_W{1'b0}};
            validdata    <= {DATA_W{1'b0}};
        end else begin
            last_r       <= next_last_s;
            iWriteEnable <= (cmd_s == GNT_W);
            Readtoa      <= (cmd_s == GNT_A);
            Readtob      <= (cmd_s == GNT_B);
            case (cmd_s)
                GNT_W: begin
                    iAddress  <= wr_addr;
                    validdata <= wr_data;
                end
                GNT_A:   iReadAddress <= rda_addr;
                GNT_B:   iReadAddress <= rdb_addr;
                default: ;
            endcase
        end
    end

    // Move read tags in step with the memory latency. Reset drops every read still in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_r[i] <= GNT_NONE;
            end
        end else begin
            tag_r[0] <= (cmd_s == GNT_W) ? GNT_NONE : cmd_s;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Capture the memory data for the reader whose tag has reached the end of the pipeline.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rda_valid <= 1'b0;
            rdb_valid <= 1'b0;
            rda_data  <= {DATA_W{1'b0}};
            rdb_data  <= {DATA_W{1'b0}};
        end else begin
            rda_valid <= (tag_r[RD_LAT] == GNT_A);
            rdb_valid <= (tag_r[RD_LAT] == GNT_B);
            if (tag_r[RD_LAT] == GNT_A) begin
                rda_data <= mem_data;
            end
            if (tag_r[RD_LAT] == GNT_B) begin
                rdb_data <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// A simple memory sits behind the DUT. The reference model is a rotating priority list, a shadow memory
// updated in ack order, and a queue of expected returns, each due 3 cycles after its ack.
module tb_mem_port_arbiter;

    logic       clk;
    logic       reset_n;
    logic       wr_req, rda_req, rdb_req;
    logic [9:0] wr_addr, rda_addr, rdb_addr;
    logic [7:0] wr_data;
    logic       wr_ack, rda_ack, rdb_ack;
    logic       rda_valid, rdb_valid;
    logic [7:0] rda_data, rdb_data;
    logic       iWriteEnable, Readtoa, Readtob;
    logic [9:0] iAddress, iReadAddress;
    logic [7:0] validdata;
    logic [7:0] mem_data;
    logic       mem_init;

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rda_req(rda_req), .rda_addr(rda_addr), .rda_ack(rda_ack),
        .rda_valid(rda_valid), .rda_data(rda_data),
        .rdb_req(rdb_req), .rdb_addr(rdb_addr), .rdb_ack(rdb_ack),
        .rdb_valid(rdb_valid), .rdb_data(rdb_data),
        .iWriteEnable(iWriteEnable), .iAddress(iAddress), .iReadAddress(iReadAddress),
        .validdata(validdata), .Readtoa(Readtoa), .Readtob(Readtob),
        .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the DUT: 1024x8 with a one-cycle read latency.
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else begin
            if (iWriteEnable === 1'b1) mem[iAddress] <= validdata;
            if (Readtoa === 1'b1 || Readtob === 1'b1) mem_data <= mem[iReadAddress];
        end
    end

    // ---------------- reference model ----------------
    typedef struct { int due; int rdr; logic [7:0] data; } ret_t;
    ret_t       pend[$];
    logic [7:0] ref_mem [1024];
    int         m_last;                 // 0 = W, 1 = A, 2 = B
    bit         exp_we, exp_ra, exp_rb, armed;
    int         exp_iaddr, exp_vdata, exp_raddr, exp_rda_data, exp_rdb_data;
    int         cyc;
    int         tests, fails;

    function automatic int pick(input int last, input bit [2:0] req);
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check at the falling edge, then advance the model.
    task automatic tick(input bit rst, input bit w, input int wa, input int wd,
                        input bit a, input int aa, input bit b, input int ba);
        bit [2:0] req;
        int       g;
        bit       exp_va, exp_vb;
        ret_t     r;
        reset_n  = rst;
        wr_req   = w;  wr_addr  = 10'(wa); wr_data = 8'(wd);
        rda_req  = a;  rda_addr = 10'(aa);
        rdb_req  = b;  rdb_addr = 10'(ba);
        @(negedge clk);
        req = {b, a, w};
        g   = rst ? pick(m_last, req) : -1;
        chk("acks{b,a,w}", 32'({rdb_ack, rda_ack, wr_ack}), 32'({g == 2, g == 1, g == 0}));
        if (armed) begin
            exp_va = 1'b0;
            exp_vb = 1'b0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].rdr == 1) begin exp_va = 1'b1; exp_rda_data = 32'(pend[i].data); end
                    else                  begin exp_vb = 1'b1; exp_rdb_data = 32'(pend[i].data); end
                end
            end
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            chk("strobes{we,ra,rb}", 32'({iWriteEnable, Readtoa, Readtob}), 32'({exp_we, exp_ra, exp_rb}));
            chk("iAddress", 32'(iAddress), exp_iaddr);
            chk("validdata", 32'(validdata), exp_vdata);
            chk("iReadAddress", 32'(iReadAddress), exp_raddr);
            chk("valids{a,b}", 32'({rda_valid, rdb_valid}), 32'({exp_va, exp_vb}));
            chk("rda_data", 32'(rda_data), exp_rda_data);
            chk("rdb_data", 32'(rdb_data), exp_rdb_data);
        end
        if (!rst) begin
            pend.delete();
            m_last = 2;
            exp_we = 1'b0; exp_ra = 1'b0; exp_rb = 1'b0;
            exp_iaddr = 0; exp_vdata = 0; exp_raddr = 0;
            exp_rda_data = 0; exp_rdb_data = 0;
            armed = 1'b1;
        end else begin
            exp_we = (g == 0); exp_ra = (g == 1); exp_rb = (g == 2);
            if (g == 0) begin ref_mem[wa] = 8'(wd); exp_iaddr = wa; exp_vdata = wd & 255; end
            if (g == 1) begin exp_raddr = aa; r.due = cyc + 3; r.rdr = 1; r.data = ref_mem[aa]; pend.push_back(r); end
            if (g == 2) begin exp_raddr = ba; r.due = cyc + 3; r.rdr = 2; r.data = ref_mem[ba]; pend.push_back(r); end
            if (g >= 0) m_last = g;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        int ra, rb, wa;
        bit rw, rr_a, rr_b, rst;
        tests = 0; fails = 0; cyc = 0; armed = 1'b0; m_last = 2;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        mem_init = 1'b1;
        reset_n = 1'b0; wr_req = 1'b0; rda_req = 1'b0; rdb_req = 1'b0;
        wr_addr = '0; rda_addr = '0; rdb_addr = '0; wr_data = '0;
        @(posedge clk); #1;
        mem_init = 1'b0;

        // Reset, then write 8 to address 0 followed by a read from A.
        do_reset();
        do_reset();
        tick(1'b1, 1'b1, 0, 8, 1'b0, 0, 1'b0, 0);
        tick(1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b0, 0);
        idle(4);

        // All three requesters held right after reset should be served W, A, B, W, A, B.
        do_reset();
        idle(1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 100 + i, 200 + i, 1'b1, 100 + i, 1'b1, 99 + i);
        idle(4);

        // Top address: a write of 64 and a B read arrive together.
        tick(1'b1, 1'b1, 1023, 64, 1'b0, 0, 1'b1, 1023);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 1023);
        idle(4);

        // Preload 1..4 into addresses 0..3, then stream four reads from A.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, i, i + 1, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 0, 0, 1'b1, i, 1'b0, 0);
        idle(5);

        // Reset while an A read is in flight; the read must never return.
        tick(1'b1, 1'b0, 0, 0, 1'b1, 2, 1'b0, 0);
        do_reset();
        idle(4);
        tick(1'b1, 1'b1, 5, 77, 1'b1, 5, 1'b1, 5);
        idle(4);

        // Two readers on the same address in consecutive cycles.
        tick(1'b1, 1'b1, 10, 16, 1'b0, 0, 1'b0, 0);
        tick(1'b1, 1'b0, 0, 0, 1'b1, 10, 1'b0, 0);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 10);
        idle(5);

        // Random traffic on a small address set plus the top address, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 59) != 0);
            rw   = 1'($urandom_range(0, 1));
            rr_a = 1'($urandom_range(0, 1));
            rr_b = 1'($urandom_range(0, 1));
            wa   = ($urandom_range(0, 5) == 0) ? 1023 : int'($urandom_range(0, 7));
            ra   = ($urandom_range(0, 5) == 0) ? 1023 : int'($urandom_range(0, 7));
            rb   = ($urandom_range(0, 5) == 0) ? 1023 : int'($urandom_range(0, 7));
            tick(rst, rw, wa, int'($urandom_range(0, 255)), rr_a, ra, rr_b, rb);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
